// File: rtl/register_file.sv
// rtl/register_file.sv - four-entry 8-bit register file with one-hot write/read select
// Optional write-through bypass on the read port: REGFILE_BYPASS_EN.
module register_file (
  input  logic       clk,
  input  logic       nReset,
  input  logic [7:0] Aku,
  input  logic       RegCE,
  input  logic [3:0] RegX,
  output logic [7:0] out
);

  logic [7:0] regs [4];
  logic [7:0] stored_rd;

  // Every selected register loads the same accumulator value; reset wins.
  always_ff @(posedge clk) begin
    if (nReset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (RegCE) begin
      for (int i = 0; i < 4; i++) begin
        if (RegX[i]) begin
          regs[i] <= Aku;
        end
      end
    end
  end

  always_comb begin
    stored_rd = 8'h00;
    if (RegX[0])      stored_rd = regs[0];
    else if (RegX[1]) stored_rd = regs[1];
    else if (RegX[2]) stored_rd = regs[2];
    else if (RegX[3]) stored_rd = regs[3];
  end

`ifdef REGFILE_BYPASS_EN
  // The priority-chosen register always has its select bit set, so any
  // non-zero select during an enabled write forwards the incoming data.
  always_comb begin
    out = stored_rd;
    if (RegCE && !nReset && (RegX != 4'b0000)) begin
      out = Aku;
    end
  end
`else
  always_comb begin
    out = stored_rd;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  logic       clk;
  logic       nReset;
  logic [7:0] Aku;
  logic       RegCE;
  logic [3:0] RegX;
  logic [7:0] out;

  int n_checks;
  int n_fail;

  register_file dut (
    .clk    (clk),
    .nReset (nReset),
    .Aku    (Aku),
    .RegCE  (RegCE),
    .RegX   (RegX),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] expected);
    #1;
    n_checks++;
    assert (out === expected) else begin
      n_fail++;
      $error("FAIL %s: out=%h expected=%h", tag, out, expected);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bypass_exp;
    n_checks = 0;
    n_fail   = 0;
    nReset   = 1'b1;
    RegCE    = 1'b1;
    RegX     = 4'b1111;
    Aku      = 8'hFF;
    @(negedge clk);

    // Reset while a full multi-hot write is requested
    edge_step();
    nReset = 1'b0;
    RegCE  = 1'b0;
    RegX = 4'b0001; check("rst_r0", 8'h00);
    RegX = 4'b0010; check("rst_r1", 8'h00);
    RegX = 4'b0100; check("rst_r2", 8'h00);
    RegX = 4'b1000; check("rst_r3", 8'h00);

    // Sequential single-hot writes
    RegCE = 1'b1;
    RegX = 4'b0001; Aku = 8'd4; edge_step();
    check("wr_r0_visible", 8'd4);
    RegX = 4'b0010; Aku = 8'd5; edge_step();
    RegX = 4'b0100; Aku = 8'd6; edge_step();
    RegX = 4'b1000; Aku = 8'd7; edge_step();
    RegCE = 1'b0;
    RegX = 4'b0001; check("rd_r0", 8'd4);
    RegX = 4'b0010; check("rd_r1", 8'd5);
    RegX = 4'b0100; check("rd_r2", 8'd6);
    RegX = 4'b1000; check("rd_r3", 8'd7);
    RegX = 4'b0000; check("rd_none", 8'h00);

    // Write disabled
    RegX = 4'b0010; Aku = 8'hAA; edge_step();
    check("wr_disabled_r1", 8'd5);

    // Multi-hot write and priority read
    RegCE = 1'b1; RegX = 4'b1010; Aku = 8'h3C; edge_step();
    RegCE = 1'b0;
    check("multi_rd_1010", 8'h3C);
    RegX = 4'b1000; check("multi_r3", 8'h3C);
    RegX = 4'b0001; check("multi_r0_kept", 8'd4);
    RegX = 4'b0100; check("multi_r2_kept", 8'd6);
    RegX = 4'b1111; check("prio_1111", 8'd4);
    RegX = 4'b1100; check("prio_1100", 8'd6);

    // Same-cycle read of a register being written
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 8'h55;
`else
    bypass_exp = 8'd6;
`endif
    RegCE = 1'b1; RegX = 4'b0100; Aku = 8'h55;
    check("bypass_pre_edge", bypass_exp);
    edge_step();
    RegCE = 1'b0;
    check("bypass_post_edge", 8'h55);

    // Reset priority over a pending write
    nReset = 1'b1; RegCE = 1'b1; RegX = 4'b0001; Aku = 8'd9;
    edge_step();
    nReset = 1'b0; RegCE = 1'b0;
    check("rst_prio_r0", 8'h00);
    RegX = 4'b0100; check("rst_prio_r2", 8'h00);
    RegX = 4'b1000; check("rst_prio_r3", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
